// File: rtl/irq_pkg.sv
// Shared definitions for the machine-level interrupt front end.
package irq_pkg;

  // Sequencer states; encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_ISR  = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  // Interrupt flag position inside mcause.
  localparam int MCAUSE_IRQ_BIT = 31;

  // Address of the vector for source 0 unless overridden.
  localparam logic [31:0] DEFAULT_ISR_BASE = 32'd52;

  // Vector address for a source; 32-bit arithmetic, wraps on overflow.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [3:0]  idx,
                                           input logic [31:0] stride);
    return base + ({28'd0, idx} * stride);
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Per-source rising-edge detector with a sticky pending bit.
// A new edge arriving in the same cycle as the clear keeps the bit set.
module irq_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic clr_i,
  output logic pending_o
);

  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic rise;

  // Next-state: remember last level, set on rise, clear unless a rise collides.
  always_comb begin
    rise      = src_i & ~prev_q;
    prev_d    = src_i;
    pending_d = rise | (pending_q & ~clr_i);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/irq_trap_sequencer.sv
// Interrupt front end beside EX: latches edges, picks the lowest-index
// eligible source, captures PC/cause, and sequences flush + redirect into
// the ISR vector and back out again on mret.
module irq_trap_sequencer
  import irq_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] ISR_BASE   = DEFAULT_ISR_BASE,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic [31:0]      pc_ex,
  input  logic             ex_valid,
  input  logic             mret_ex,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      mepc,
  output logic [31:0]      mcause,
  output logic [N_SRC-1:0] irq_ack,
  output logic [N_SRC-1:0] pending,
  output logic             in_isr
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [N_SRC-1:0] eligible;
  logic             win_found;
  logic [3:0]       win_idx;

  // Per-source edge latches; a source is cleared only in its own TRAP cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign irq_ack[gi] = (state_q == ST_TRAP) && (idx_q == 4'(gi));
      irq_edge_latch u_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_i    (irq_src[gi]),
        .clr_i    (irq_ack[gi]),
        .pending_o(pending[gi])
      );
    end
  endgenerate

  assign eligible = pending & irq_mask;

  // Fixed-priority encoder: lowest eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_idx   = 4'(i);
      end
    end
  end

  // State, winner index and trap CSR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Next-state: trap only on a real EX instruction; no nesting while in ISR.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found && ex_valid) begin
          state_d                  = ST_TRAP;
          idx_d                    = win_idx;
          mepc_d                   = pc_ex;
          mcause_d                 = {28'd0, win_idx};
          mcause_d[MCAUSE_IRQ_BIT] = 1'b1;
        end
      end
      ST_TRAP: state_d = ST_ISR;
      ST_ISR:  if (mret_ex) state_d = ST_RET;
      ST_RET:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state so they never glitch.
  always_comb begin
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    unique case (state_q)
      ST_TRAP: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = vec_addr(ISR_BASE, idx_q, 32'(VEC_STRIDE));
      end
      ST_RET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc_q;
      end
      default: ;
    endcase
  end

  assign in_isr = (state_q == ST_TRAP) || (state_q == ST_ISR);
  assign mepc   = mepc_q;
  assign mcause = mcause_q;

endmodule
